div_unit: RTL and testbench
===========================

# div_unit

Iterative 64-bit integer divider for the RV64M DIV/DIVU/REM/REMU instructions. It sits beside the 64-bit signed ALU adder in the execute stage, and takes the same register-file operands `rs1` and `rs2`. Its registered result feeds the writeback mux in place of the ALU output. A restoring shift-subtract algorithm produces one quotient bit per cycle, and a start/busy/done handshake stalls the datapath while the divide runs.

## Interface
- `XLEN`, 64: operand and result width. Only 64 is supported.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request pulse. Sampled on a rising edge while `busy`=0.
- `op` input 2: operation select. 00=DIV, 01=DIVU, 10=REM, 11=REMU.
- `rs1` input 64: dividend. Two's complement for DIV/REM.
- `rs2` input 64: divisor. Two's complement for DIV/REM.
- `busy` output 1: high while a divide is in progress.
- `done` output 1: single-cycle pulse; `result` is valid in this cycle.
- `result` output 64: quotient or remainder. Holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE with `start`=1 at an edge:
  - Latch `op`.
  - Load the magnitudes `|rs1|` and `|rs2|` (raw values for DIVU/REMU).
  - Record `neg_q` = sign(rs1) XOR sign(rs2) and `neg_r` = sign(rs1). Both are 0 for unsigned ops.
  - Clear the 65-bit partial remainder and the 6-bit counter. Go to CALC and set `busy`=1.
- CALC, one step per edge:
  - Shift {rem, quo} left by one.
  - Trial-subtract the divisor from the upper 65 bits.
  - On a non-negative trial, keep the difference and set quotient bit 0 to 1.
  - Increment the counter. On the edge where counter==63, go to FIN.
- FIN, one edge:
  - Select the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - Negate (two's complement) when `neg_q` applies (quotient) or `neg_r` applies (remainder).
  - Register the value into `result`, pulse `done`=1, drop `busy`, return to IDLE.
- Divisor zero, handled in the normal path:
  - Quotient = all ones (DIV returns -1, DIVU returns 2^64-1).
  - Remainder = `rs1` unmodified.
  - Sign correction is suppressed for this case.
- Signed overflow (rs1=0x8000_0000_0000_0000, rs2=-1, op DIV/REM): quotient = 0x8000_0000_0000_0000, remainder = 0.
- `start` while `busy`=1 is ignored. The operands in flight are unaffected.
- `start` in the same cycle as `done`: accepted, because the state is IDLE.
- `rst_n` low, at any time including mid-CALC:
  - Go to IDLE immediately.
  - `busy`=0, `done`=0, `result`=0; counter and internal registers cleared.
  - No `done` is issued for the aborted operation.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=64'h0.
- Start accepted at edge E0. `busy` is high from after E0 through the edge E65.
- CALC steps occur at edges E1..E64. FIN occurs at E65.
- `done`=1 and the new `result` are visible for exactly one cycle after E65. Latency is 65 cycles.
- `done` is never high for two consecutive cycles unless a back-to-back early-out occurs (see Configuration).
- Inputs `op`, `rs1` and `rs2` only need to be stable in the cycle that `start` is sampled.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - At the accepting edge, a zero divisor or signed overflow skips CALC and FIN.
  - The special-case `result` is written directly, `done` pulses in the next cycle, and `busy` stays 0.
  - Latency is 1 cycle.
- Undefined: special cases run the full 65-cycle path with identical result values.
- All other operations are unaffected either way.

## Test plan
- DIV rs1=100, rs2=7 -> `done` 65 cycles after start, `result`=14. REM with the same operands -> 2.
- DIV rs1=-100, rs2=7 -> `result`=-14 (0xFFFF_FFFF_FFFF_FFF2). REM -> -2. DIVU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> 0x7FFF_FFFF_FFFF_FFFF.
- Divide by zero, rs1=-34359738368, rs2=0:
  - DIV -> 0xFFFF_FFFF_FFFF_FFFF and REM -> 0xFFFF_FFF8_0000_0000.
  - Latency 65 cycles without `DIV_EARLY_OUT_EN`, 1 cycle with it.
- Overflow rs1=0x8000_0000_0000_0000, rs2=-1 -> DIV `result`=0x8000_0000_0000_0000, REM `result`=0.
- Start DIV 100/7, pulse `start` with 50/5 at cycle 10 -> the second start is ignored; the single `done` carries 14.
- Assert `rst_n`=0 at cycle 30 of a divide -> `busy`=0, `result`=0 immediately, no `done`. A fresh start after release completes normally.

Source files
------------

// File: rtl/div_unit.sv
// Iterative 64-bit restoring divider for RV64M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish at the accepting edge.
module div_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t          state_q;
   logic            busy_q, done_q, is_rem_q, neg_q_q, neg_r_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN:0]   rem_q;
   logic [XLEN-1:0] quo_q, dvs_q, result_q;

   logic            signed_op, rs1_neg, rs2_neg, div_zero, trial_ok;
   logic [XLEN-1:0] rs1_mag, rs2_mag, quo_d, fin_sel, fin_val;
   logic [XLEN+1:0] rem_shift;
   logic [XLEN:0]   diff, rem_d;
   logic            fin_neg;

   assign signed_op = ~op[0];
   assign rs1_neg   = signed_op & rs1[XLEN-1];
   assign rs2_neg   = signed_op & rs2[XLEN-1];
   assign rs1_mag   = rs1_neg ? -rs1 : rs1;
   assign rs2_mag   = rs2_neg ? -rs2 : rs2;
   assign div_zero  = (rs2 == '0);

   // Shift {rem, quo} left one place and trial-subtract the divisor magnitude.
   assign rem_shift = {rem_q, quo_q[XLEN-1]};
   assign trial_ok  = (rem_shift >= {2'b00, dvs_q});
   assign diff      = rem_shift[XLEN:0] - {1'b0, dvs_q};
   assign rem_d     = trial_ok ? diff : rem_shift[XLEN:0];
   assign quo_d     = {quo_q[XLEN-2:0], trial_ok};

   assign fin_sel   = is_rem_q ? rem_q[XLEN-1:0] : quo_q;
   assign fin_neg   = is_rem_q ? neg_r_q : neg_q_q;
   assign fin_val   = fin_neg ? -fin_sel : fin_sel;

`ifdef DIV_EARLY_OUT_EN
   logic            ovf;
   logic [XLEN-1:0] special_val;
   assign ovf = signed_op && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
   assign special_val = op[1] ? (div_zero ? rs1 : '0)
                              : (div_zero ? '1  : {1'b1, {(XLEN-1){1'b0}}});
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         is_rem_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
`ifdef DIV_EARLY_OUT_EN
                  if (div_zero || ovf) begin
                     result_q <= special_val;
                     done_q   <= 1'b1;
                  end else
`endif
                  begin
                     is_rem_q <= op[1];
                     quo_q    <= rs1_mag;
                     dvs_q    <= rs2_mag;
                     // A zero divisor yields all-ones quotient, never sign corrected;
                     // the remainder negation naturally restores rs1.
                     neg_q_q  <= (rs1_neg ^ rs2_neg) & ~div_zero;
                     neg_r_q  <= rs1_neg;
                     rem_q    <= '0;
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) state_q <= FIN;
            end
            FIN: begin
               result_q <= fin_val;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases, busy handling, reset abort.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [63:0] rs1 = '0;
   logic [63:0] rs2 = '0;
   logic        busy, done;
   logic [63:0] result;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
   localparam int NORMAL_EDGES = 65;
   // Edges after the accepting edge before done is seen high.
`ifdef DIV_EARLY_OUT_EN
   localparam int SPECIAL_EDGES = 0;
   localparam logic SPECIAL_BUSY = 1'b0;
`else
   localparam int SPECIAL_EDGES = 65;
   localparam logic SPECIAL_BUSY = 1'b1;
`endif

   div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Issue one operation; report result, edges to done, busy after accept, and done one edge later.
   task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output logic busy_seen,
                         output logic done_next);
      @(negedge clk);
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_seen = busy;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      @(posedge clk); #1;
      done_next = done;
      $display("op=%0d rs1=%h rs2=%h -> result=%h edges=%0d", o, a, b, res, lat);
   endtask

   task automatic test_reset();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_div_basic();
      logic [63:0] r; int lat; logic b, dn;
      run_op(OP_DIV, 64'd100, 64'd7, r, lat, b, dn);
      checks++; if (r !== 64'd14) begin errors++; $display("FAIL div_100_7 got %h want %h", r, 64'd14); end
      checks++; if (lat !== NORMAL_EDGES) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, NORMAL_EDGES); end
      checks++; if (b !== 1'b1) begin errors++; $display("FAIL div_busy got %b want 1", b); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL div_done_pulse got %b want 0", dn); end
      run_op(OP_REM, 64'd100, 64'd7, r, lat, b, dn);
      checks++; if (r !== 64'd2) begin errors++; $display("FAIL rem_100_7 got %h want %h", r, 64'd2); end
   endtask

   task automatic test_signed();
      logic [63:0] r; int lat; logic b, dn;
      run_op(OP_DIV, -64'sd100, 64'd7, r, lat, b, dn);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin errors++; $display("FAIL div_m100_7 got %h want fffffffffffffff2", r); end
      run_op(OP_REM, -64'sd100, 64'd7, r, lat, b, dn);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL rem_m100_7 got %h want fffffffffffffffe", r); end
      run_op(OP_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, lat, b, dn);
      checks++; if (r !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_max_2 got %h want 7fffffffffffffff", r); end
      run_op(OP_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10, r, lat, b, dn);
      checks++; if (r !== 64'd5) begin errors++; $display("FAIL remu_max_10 got %h want 5", r); end
   endtask

   task automatic test_div_zero();
      logic [63:0] r; int lat; logic b, dn;
      run_op(OP_DIV, 64'hFFFF_FFF8_0000_0000, 64'd0, r, lat, b, dn);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_by_zero got %h want ffffffffffffffff", r); end
      checks++; if (lat !== SPECIAL_EDGES) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, SPECIAL_EDGES); end
      checks++; if (b !== SPECIAL_BUSY) begin errors++; $display("FAIL dz_busy got %b want %b", b, SPECIAL_BUSY); end
      checks++; if (dn !== 1'b0) begin errors++; $display("FAIL dz_done_pulse got %b want 0", dn); end
      run_op(OP_REM, 64'hFFFF_FFF8_0000_0000, 64'd0, r, lat, b, dn);
      checks++; if (r !== 64'hFFFF_FFF8_0000_0000) begin errors++; $display("FAIL rem_by_zero got %h want fffffff800000000", r); end
      run_op(OP_DIVU, 64'd12345, 64'd0, r, lat, b, dn);
      checks++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL divu_by_zero got %h want ffffffffffffffff", r); end
   endtask

   task automatic test_overflow();
      logic [63:0] r; int lat; logic b, dn;
      run_op(OP_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, b, dn);
      checks++; if (r !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_div got %h want 8000000000000000", r); end
      checks++; if (lat !== SPECIAL_EDGES) begin errors++; $display("FAIL ovf_latency got %0d want %0d", lat, SPECIAL_EDGES); end
      run_op(OP_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, lat, b, dn);
      checks++; if (r !== 64'h0) begin errors++; $display("FAIL ovf_rem got %h want 0", r); end
   endtask

   task automatic test_busy_ignore();
      int lat; int extra_done;
      @(negedge clk);
      op = OP_DIV; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 0;
      repeat (9) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      rs1 = 64'd50; rs2 = 64'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat++;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      $display("busy_ignore result=%h edges=%0d", result, lat);
      checks++; if (result !== 64'd14) begin errors++; $display("FAIL ignore_result got %h want %h", result, 64'd14); end
      checks++; if (lat !== NORMAL_EDGES) begin errors++; $display("FAIL ignore_latency got %0d want %0d", lat, NORMAL_EDGES); end
      extra_done = 0;
      repeat (70) begin @(posedge clk); #1; if (done) extra_done++; end
      checks++; if (extra_done !== 0) begin errors++; $display("FAIL ignore_extra_done got %0d want 0", extra_done); end
   endtask

   task automatic test_reset_abort();
      logic [63:0] r; int lat; logic b, dn; int done_cnt;
      @(negedge clk);
      op = OP_DIV; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      $display("abort busy=%b done=%b result=%h", busy, done, result);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      checks++; if (result !== 64'h0) begin errors++; $display("FAIL abort_result got %h want 0", result); end
      done_cnt = 0;
      repeat (3) begin @(posedge clk); #1; if (done) done_cnt++; end
      @(negedge clk); rst_n = 1'b1;
      repeat (70) begin @(posedge clk); #1; if (done) done_cnt++; end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", done_cnt); end
      run_op(OP_DIVU, 64'd1000, 64'd33, r, lat, b, dn);
      checks++; if (r !== 64'd30) begin errors++; $display("FAIL post_abort got %h want %h", r, 64'd30); end
      checks++; if (lat !== NORMAL_EDGES) begin errors++; $display("FAIL post_abort_latency got %0d want %0d", lat, NORMAL_EDGES); end
   endtask

   initial begin
      test_reset();
      test_div_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_busy_ignore();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
